// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer, instruction memory, execute redirect and decode.
// master = sequencer side, slave = surrounding pipeline/memory side.
interface pc_sequencer_if;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_target;
  logic        io_inst_valid;
  logic        io_inst_ready;
  logic [31:0] io_inst;
  logic [31:0] io_inst_pc;
  logic [3:0]  io_pc_sel;
  logic [31:0] io_pc;

  modport master (
    output io_imem_req_valid, io_imem_req_addr, io_inst_valid, io_inst, io_inst_pc,
           io_pc_sel, io_pc,
    input  io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data, io_redirect_valid,
           io_redirect_target, io_inst_ready
  );

  modport slave (
    input  io_imem_req_valid, io_imem_req_addr, io_inst_valid, io_inst, io_inst_pc,
           io_pc_sel, io_pc,
    output io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data, io_redirect_valid,
           io_redirect_target, io_inst_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// Single-outstanding fetch sequencer: PC register, one-entry instruction buffer to decode.
// Requests issue only when the buffer is empty or draining; redirects squash in-flight fetches.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  pc_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_KILL = 2'd3;

  localparam logic [3:0] SEL_INC  = 4'h0;
  localparam logic [3:0] SEL_HOLD = 4'h1;
  localparam logic [3:0] SEL_JMP  = 4'h2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] tag;
  logic        buf_vld;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;

  logic        redirect;
  logic        resp;
  logic        drain;
  logic        req_vld;
  logic        accept;
  logic        fill;
  logic [3:0]  pc_sel;

  always_comb begin
    redirect = bus.io_redirect_valid;
    resp     = bus.io_imem_resp_valid;
    drain    = buf_vld & bus.io_inst_ready;
    req_vld  = !reset && (state == S_REQ) && (!buf_vld || drain);
    accept   = req_vld & bus.io_imem_req_ready;
    // A response racing a redirect belongs to the squashed path, so it never fills.
    fill     = (state == S_WAIT) && resp && !redirect;

    if (reset)         pc_sel = SEL_HOLD;
    else if (redirect) pc_sel = SEL_JMP;
    else if (accept)   pc_sel = SEL_INC;
    else               pc_sel = SEL_HOLD;

    case (pc_sel)
      SEL_INC: pc_next = pc + 32'd4;
      SEL_JMP: pc_next = bus.io_redirect_target & ~32'h3;
      default: pc_next = pc;
    endcase

    state_next = state;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (accept) state_next = redirect ? S_KILL : S_WAIT;
      end
      S_WAIT: begin
        if (resp)          state_next = S_REQ;
        else if (redirect) state_next = S_KILL;
      end
      S_KILL: begin
        if (resp) state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_VEC;
      tag      <= 32'h0;
      buf_vld  <= 1'b0;
      buf_inst <= 32'h0;
      buf_pc   <= 32'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (accept) tag <= pc;
      if (redirect) begin
        buf_vld <= 1'b0;
      end else if (fill) begin
        buf_vld  <= 1'b1;
        buf_inst <= bus.io_imem_resp_data;
        buf_pc   <= tag;
      end else if (drain) begin
        buf_vld <= 1'b0;
      end
    end
  end

  // Outputs are forced to their reset values combinationally so they are clean from the first reset cycle.
  always_comb begin
    bus.io_imem_req_valid = req_vld;
    bus.io_pc             = reset ? RESET_VEC : pc;
    bus.io_imem_req_addr  = reset ? RESET_VEC : pc;
    bus.io_pc_sel         = pc_sel;
    bus.io_inst_valid     = buf_vld & !reset;
    bus.io_inst           = reset ? 32'h0 : buf_inst;
    bus.io_inst_pc        = reset ? 32'h0 : buf_pc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then randomized traffic against a transaction-level model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VEC(RV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  // Reference model: PC, whether a fetch is in flight (and whether it is squashed), buffer contents.
  logic [31:0] m_pc, m_oaddr, m_bi, m_bp;
  bit          m_idle, m_out, m_dead, m_bv;

  // Instruction memory model.
  bit          mem_busy = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;
  int          lat_lo   = 0;
  int          lat_hi   = 0;

  logic [31:0] acc_q[$];
  bit          last_acc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_idle = 1; m_out = 0; m_dead = 0; m_bv = 0;
    m_oaddr = 32'h0; m_bi = 32'h0; m_bp = 32'h0;
  endtask

  task automatic step(input logic r, input logic qrdy, input logic irdy,
                      input logic rv, input logic [31:0] rt);
    bit          mem_fire, exp_rv, exp_acc, filled;
    logic [3:0]  exp_sel;
    logic [31:0] cur_pc;
    @(negedge clock);
    reset = r;
    bus.io_imem_req_ready  = qrdy;
    bus.io_inst_ready      = irdy;
    bus.io_redirect_valid  = rv;
    bus.io_redirect_target = rt;
    mem_fire = 0;
    if (mem_busy && mem_cnt == 0) begin
      bus.io_imem_resp_valid = 1'b1;
      bus.io_imem_resp_data  = mem_word(mem_addr);
      mem_fire = 1;
    end else if (!mem_busy && !m_out && $urandom_range(0, 7) == 0) begin
      bus.io_imem_resp_valid = 1'b1;
      bus.io_imem_resp_data  = $urandom;
    end else begin
      bus.io_imem_resp_valid = 1'b0;
      bus.io_imem_resp_data  = $urandom;
    end
    #1;
    exp_acc = 0;
    cur_pc  = m_pc;
    if (r) begin
      chk("rst_req_valid", {31'b0, bus.io_imem_req_valid}, 32'd0);
      chk("rst_inst_valid", {31'b0, bus.io_inst_valid}, 32'd0);
      chk("rst_pc_sel", {28'b0, bus.io_pc_sel}, 32'd1);
      chk("rst_pc", bus.io_pc, RV);
      chk("rst_inst", bus.io_inst, 32'd0);
      chk("rst_inst_pc", bus.io_inst_pc, 32'd0);
      model_reset();
      last_acc = 0;
    end else begin
      exp_rv  = !m_idle && !m_out && (!m_bv || irdy);
      exp_acc = exp_rv && qrdy;
      exp_sel = rv ? 4'h2 : (exp_acc ? 4'h0 : 4'h1);
      chk("req_valid", {31'b0, bus.io_imem_req_valid}, {31'b0, exp_rv});
      chk("req_addr", bus.io_imem_req_addr, m_pc);
      chk("pc", bus.io_pc, m_pc);
      chk("pc_sel", {28'b0, bus.io_pc_sel}, {28'b0, exp_sel});
      chk("inst_valid", {31'b0, bus.io_inst_valid}, {31'b0, m_bv});
      if (m_bv) begin
        chk("inst", bus.io_inst, m_bi);
        chk("inst_pc", bus.io_inst_pc, m_bp);
      end
      last_acc = bus.io_imem_req_valid && qrdy;
      if (last_acc) acc_q.push_back(bus.io_imem_req_addr);

      filled = 0;
      if (bus.io_imem_resp_valid && m_out) begin
        if (!m_dead && !rv) begin
          filled = 1; m_bv = 1; m_bi = bus.io_imem_resp_data; m_bp = m_oaddr;
        end
        m_out = 0;
      end
      if (!filled && m_bv && irdy) m_bv = 0;
      if (rv) begin
        m_bv = 0;
        if (m_out) m_dead = 1;
      end
      if (exp_acc) begin
        m_out = 1; m_oaddr = m_pc; m_dead = rv;
      end
      if (rv)           m_pc = rt & ~32'h3;
      else if (exp_acc) m_pc = m_pc + 32'd4;
      m_idle = 0;
    end
    if (mem_fire)                     mem_busy = 0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (exp_acc) begin
      mem_busy = 1;
      mem_addr = cur_pc;
      mem_cnt  = $urandom_range(lat_lo, lat_hi);
    end
  endtask

  task automatic wait_acc(input string tag);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 0, 32'h0);
      if (last_acc) break;
    end
    chk(tag, {31'b0, last_acc}, 32'd1);
  endtask

  task automatic wait_first_acc(input string tag, input logic [31:0] exp);
    acc_q.delete();
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 0, 32'h0);
      if (acc_q.size() > 0) break;
    end
    chk({tag, "_seen"}, acc_q.size(), 32'd1);
    if (acc_q.size() > 0) chk(tag, acc_q[0], exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.io_imem_req_ready  = 1'b0;
    bus.io_imem_resp_valid = 1'b0;
    bus.io_imem_resp_data  = 32'h0;
    bus.io_redirect_valid  = 1'b0;
    bus.io_redirect_target = 32'h0;
    bus.io_inst_ready      = 1'b0;
    model_reset();

    // Reset, including a redirect presented while reset is high.
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 1, 32'h4000);
    step(1, 1, 1, 0, 32'h0);

    // Straight-line fetch with a 1-cycle memory.
    lat_lo = 0; lat_hi = 0;
    acc_q.delete();
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 32'h0);
    chk("seq_count", {31'b0, acc_q.size() >= 3}, 32'd1);
    if (acc_q.size() >= 3) begin
      chk("seq_addr0", acc_q[0], 32'h0);
      chk("seq_addr1", acc_q[1], 32'h4);
      chk("seq_addr2", acc_q[2], 32'h8);
    end

    // Decode stalls with the buffer full.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h0);

    // Redirect while waiting; the response arrives two cycles later and is squashed.
    lat_lo = 2; lat_hi = 2;
    wait_acc("t034_accept");
    step(0, 1, 1, 1, 32'h0000_1003);
    @(posedge clock); #1;
    chk("t034_pc", bus.io_pc, 32'h0000_1000);
    wait_first_acc("t034_next_addr", 32'h0000_1000);

    // Redirect coinciding with the response.
    lat_lo = 0; lat_hi = 0;
    wait_acc("t035_accept");
    step(0, 1, 1, 1, 32'h0000_2000);
    @(posedge clock); #1;
    chk("t035_inst_valid", {31'b0, bus.io_inst_valid}, 32'd0);
    wait_first_acc("t035_next_addr", 32'h0000_2000);

    // PC wraps past the top of the address space.
    step(0, 1, 1, 1, 32'hFFFF_FFFF);
    wait_first_acc("t036_addr", 32'hFFFF_FFFC);
    @(posedge clock); #1;
    chk("t036_wrap", bus.io_pc, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 32'h0);

    // Reset during a fetch; the late response must not surface.
    lat_lo = 2; lat_hi = 2;
    wait_acc("t037_accept");
    step(1, 1, 1, 0, 32'h0);
    wait_first_acc("t037_first_addr", RV);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 32'h0);

    // Randomized traffic.
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
